scan_index_sequencer: RTL and testbench
=======================================

// Module: scan_index_sequencer
// PURPOSE
//  Upstream driver for the 3:8 one-hot decoder. Walks a 3-bit channel index over the enabled
//  channels of an 8-bit mask and holds each channel for a programmable dwell time. Drives the
//  decoder's in[2:0]/en pair, e.g. for row scanning or chip-select sequencing.
//  Runs single-frame or continuous, and pulses once at the end of each frame.
// PARAMETERS
//  DWELL_W  8  width of the dwell input; each channel is held dwell+1 cycles (1..2^DWELL_W)
// PORTS
//  clk         in   1        single clock; everything is on the rising edge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        begin a scan; sampled only in IDLE
//  stop        in   1        abort the scan; sampled in any state
//  continuous  in   1        1: repeat frames until stop; 0: run one frame; sampled with start
//  chan_mask   in   8        bit i=1 -> channel i is visited
//  dwell       in   DWELL_W  hold count per channel, minus one
//  sel         out  3        channel index -> decoder in[2:0]
//  sel_en      out  1        channel-active strobe -> decoder en
//  busy        out  1        high in every state except IDLE
//  frame_done  out  1        one-cycle pulse after the last enabled channel of a frame
// BEHAVIOUR
//  - All outputs are registered. Reset values: sel=0, sel_en=0, busy=0, frame_done=0, state=IDLE.
//  - States: IDLE, DWELL, BLANK (BLANK exists only with the macro).
//  - IDLE: on start=1 with chan_mask!=0 and stop=0:
//      latch mask, dwell and continuous; sel=lowest set mask bit; go to DWELL.
//      The next cycle has sel_en=1, busy=1 (1-cycle start latency).
//  - IDLE: start with chan_mask==0 is ignored; start and stop together -> stop wins, start ignored.
//  - DWELL: sel_en=1, the dwell counter counts 0..dwell_q. On the terminal count:
//      with the macro -> go to BLANK; without -> advance immediately (see below).
//  - Advance: next index = next set bit of mask_q above sel, wrapping past 7.
//    Wrap means the next index is <= sel, which includes a single-bit mask.
//      On wrap: frame_done=1 for 1 cycle, coincident with the first cycle of the next channel
//      (or of IDLE).
//      On wrap with continuous_q=1: re-latch chan_mask and dwell; if the new mask is 0, go to
//      IDLE. Otherwise continue from the lowest set bit of the new mask.
//      On wrap with continuous_q=0: go to IDLE; sel holds its last value, sel_en=0, busy=0.
//  - stop=1 in DWELL/BLANK: next cycle state=IDLE, sel_en=0, busy=0, frame_done=0.
//    No end-of-frame pulse is produced.
//  - start while busy is ignored; mask/dwell input changes mid-frame have no effect until re-latch.
//  - rst mid-scan overrides everything: the next cycle shows the reset values.
//  - sel changes only while sel_en=0 (macro on) or on a dwell boundary (macro off).
//  - The dwell counter is DWELL_W bits wide, compares for equality with dwell_q, and never overflows.
// CONFIGURATION
//  SCAN_BLANK_EN defined:
//      one BLANK cycle (sel_en=0) between consecutive channels, including across frames.
//      Break-before-make on decoder outputs; per-channel period = dwell+2.
//  SCAN_BLANK_EN undefined:
//      no BLANK state; sel_en stays 1 across channel changes within and across continuous frames.
//      Per-channel period = dwell+1.
// STRUCTURE
//  Shared package scan_seq_pkg: state encodings (IDLE/DWELL/BLANK), NCHAN=8, IDX_W=3.
//  One sub-module: next_chan_find
//      combinational; inputs mask[7:0], cur[2:0]; outputs nxt[2:0], wrap, first[2:0].
//      first = lowest set bit of mask.
//  Top level: FSM, dwell counter, latched mask/dwell/continuous registers, output registers.
// TESTING
//  1 reset: assert rst mid-DWELL, mask=8'hFF -> next cycle sel=0, sel_en=0, busy=0, frame_done=0.
//  2 single frame: mask=8'b1010_0101, dwell=2, continuous=0, start ->
//      sel visits 0,2,5,7, each held 3 cycles with sel_en=1 (+1 blank cycle with the macro);
//      frame_done pulses once, then IDLE.
//  3 continuous wrap, single channel: mask=8'h10, dwell=0 ->
//      sel=4 held, frame_done pulses every 1 cycle (macro off) or every 2 cycles (macro on).
//  4 stop mid-channel: stop at dwell count 1 on sel=3 -> next cycle sel_en=0, busy=0,
//      no frame_done; a later start resumes from the lowest set bit.
//  5 ignored starts: start with mask=0 -> busy stays 0;
//      start and stop together in IDLE -> stays IDLE; start while busy -> sequence unchanged.
//  6 re-latch: continuous=1, mask changed 8'h03->8'h80 mid-frame ->
//      current frame still covers 0,1; the next frame covers only 7.

Source files
------------

// File: rtl/scan_index_sequencer_pkg.sv
// Shared definitions for the scan index sequencer: FSM state encodings,
// channel count / index width and a lowest-set-bit helper.
package scan_seq_pkg;

  localparam int NCHAN = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Index of the lowest set bit of m; 0 when m is empty (callers qualify with m != 0).
  function automatic logic [IDX_W-1:0] first_set(input logic [NCHAN-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/scan_index_sequencer_next_chan_find.sv
// next_chan_find: combinational search for the next enabled channel above cur,
// wrapping past the top index. wrap is set when the search came back to an
// index at or below cur (this covers a mask with a single bit set).
module next_chan_find
  import scan_seq_pkg::*;
(
  input  logic [NCHAN-1:0] mask,
  input  logic [IDX_W-1:0] cur,
  output logic [IDX_W-1:0] nxt,
  output logic             wrap,
  output logic [IDX_W-1:0] first
);

  // Lowest enabled channel of the mask.
  always_comb begin
    first = first_set(mask);
  end

  // Scan cur+1, cur+2, ... cur+NCHAN (mod NCHAN) and take the first hit.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCHAN; k++) begin
      idx = cur + IDX_W'(k);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/scan_index_sequencer.sv
// scan_index_sequencer: walks a 3-bit channel index over the enabled bits of
// an 8-bit mask, holding each channel for dwell+1 cycles, and drives a 3:8
// decoder's in/en pair. Single-frame or continuous; frame_done pulses once
// per completed frame.
//
// Build option: define SCAN_BLANK_EN to insert one BLANK cycle (sel_en=0)
// between consecutive channels for break-before-make decoder switching.
// Without it the sequencer moves straight from one channel to the next and
// sel_en stays high across channel changes.
module scan_index_sequencer
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [NCHAN-1:0]   chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [IDX_W-1:0]   sel,
  output logic               sel_en,
  output logic               busy,
  output logic               frame_done
);

  state_t             state;
  state_t             state_d;
  state_t             adv_state;

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_d;
  logic [DWELL_W-1:0] dwell_q;
  logic [NCHAN-1:0]   mask_q;
  logic               cont_q;

  logic [NCHAN-1:0]   find_mask;
  logic [IDX_W-1:0]   nxt;
  logic [IDX_W-1:0]   first;
  logic               wrap;

  logic               accept;
  logic               term;
  logic               adv;
  logic               relatch;
  logic               ld_cfg;

  logic [IDX_W-1:0]   sel_d;
  logic               sel_en_d;
  logic               busy_d;
  logic               frame_done_d;

  // In IDLE the finder looks at the live mask so its first output gives the
  // start channel; while scanning it walks the latched mask.
  assign find_mask = (state == ST_IDLE) ? chan_mask : mask_q;

  next_chan_find u_find (
    .mask  (find_mask),
    .cur   (sel),
    .nxt   (nxt),
    .wrap  (wrap),
    .first (first)
  );

  assign accept = (state == ST_IDLE) && start && !stop && (chan_mask != '0);
  assign term   = (cnt == dwell_q);

  // adv marks the cycle in which the move to the next channel is decided.
`ifdef SCAN_BLANK_EN
  assign adv = (state == ST_BLANK) && !stop;
`else
  assign adv = (state == ST_DWELL) && term && !stop;
`endif

  assign relatch = adv && wrap && cont_q;
  assign ld_cfg  = accept || relatch;

  // Where an advance leads: next channel, a fresh continuous frame, or IDLE.
  assign adv_state = !wrap                          ? ST_DWELL :
                     (cont_q && (chan_mask != '0)) ? ST_DWELL : ST_IDLE;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic; stop aborts from any active state without a frame pulse.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_d = ST_DWELL;
      end
      ST_DWELL: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (term) begin
`ifdef SCAN_BLANK_EN
          state_d = ST_BLANK;
`else
          state_d = adv_state;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      ST_BLANK: begin
        if (stop) state_d = ST_IDLE;
        else      state_d = adv_state;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; sel only moves on an accepted start or an advance.
  always_comb begin
    sel_d = sel;
    if (accept) begin
      sel_d = first;
    end else if (adv) begin
      if (!wrap)                            sel_d = nxt;
      else if (relatch && chan_mask != '0) sel_d = first_set(chan_mask);
    end

    cnt_d = '0;
    if (state == ST_DWELL && state_d == ST_DWELL && !term) cnt_d = cnt + DWELL_W'(1);

    sel_en_d     = (state_d == ST_DWELL);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = adv && wrap;
  end

  // Registered outputs and dwell counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= '0;
      sel_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
    end else begin
      sel        <= sel_d;
      sel_en     <= sel_en_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
      cnt        <= cnt_d;
    end
  end

  // Frame configuration, captured on start and again at each continuous wrap.
  always_ff @(posedge clk) begin
    if (ld_cfg) begin
      mask_q  <= chan_mask;
      dwell_q <= dwell;
    end
    if (accept) cont_q <= continuous;
  end

endmodule

// File: tb/tb_scan_index_sequencer.sv
// Directed bench for scan_index_sequencer. Observed vector is
// {sel[2:0], sel_en, busy, frame_done}; expected values are hand-derived.
module tb_scan_index_sequencer;

  localparam int DWELL_W = 8;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic               continuous;
  logic [7:0]         chan_mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               sel_en;
  logic               busy;
  logic               frame_done;

  logic [5:0]         obs;
  logic [5:0]         want;
  int                 pass_cnt;
  int                 total_cnt;

  assign obs = {sel, sel_en, busy, frame_done};

  scan_index_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .chan_mask  (chan_mask),
    .dwell      (dwell),
    .sel        (sel),
    .sel_en     (sel_en),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    chan_mask = 8'h00; dwell = '0;
    step; step;
    want = 6'b000_0_0_0; total_cnt++;
    if (obs !== want) $display("FAIL reset_idle got %b want %b", obs, want); else pass_cnt++;
    rst = 1'b0; chan_mask = 8'hFF; dwell = 8'd5; continuous = 1'b1; start = 1'b1;
    step; start = 1'b0;
    want = {3'd0, 1'b1, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL start_latency got %b want %b", obs, want); else pass_cnt++;
    step; step;
    rst = 1'b1;
    step;
    want = 6'b000_0_0_0; total_cnt++;
    if (obs !== want) $display("FAIL reset_mid_dwell got %b want %b", obs, want); else pass_cnt++;
    rst = 1'b0;
    step;
    total_cnt++;
    if (obs !== want) $display("FAIL reset_stays_idle got %b want %b", obs, want); else pass_cnt++;
  endtask

  task automatic test_single_frame;
    logic [2:0] ch [4];
    ch = '{3'd0, 3'd2, 3'd5, 3'd7};
    chan_mask = 8'b1010_0101; dwell = 8'd2; continuous = 1'b0; start = 1'b1;
    step; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        want = {ch[i], 1'b1, 1'b1, 1'b0}; total_cnt++;
        if (obs !== want) $display("FAIL frame_ch%0d_cyc%0d got %b want %b", ch[i], c, obs, want);
        else pass_cnt++;
        step;
      end
`ifdef SCAN_BLANK_EN
      want = {ch[i], 1'b0, 1'b1, 1'b0}; total_cnt++;
      if (obs !== want) $display("FAIL frame_blank%0d got %b want %b", ch[i], obs, want); else pass_cnt++;
      step;
`endif
    end
    want = {3'd7, 1'b0, 1'b0, 1'b1}; total_cnt++;
    if (obs !== want) $display("FAIL frame_done_pulse got %b want %b", obs, want); else pass_cnt++;
    step;
    want = {3'd7, 1'b0, 1'b0, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL frame_idle_after got %b want %b", obs, want); else pass_cnt++;
  endtask

  task automatic test_continuous_single;
    chan_mask = 8'h10; dwell = 8'd0; continuous = 1'b1; start = 1'b1;
    step; start = 1'b0;
    for (int i = 0; i < 8; i++) begin
`ifdef SCAN_BLANK_EN
      want = {3'd4, (i % 2 == 0), 1'b1, (i > 0 && i % 2 == 0)};
`else
      want = {3'd4, 1'b1, 1'b1, (i > 0)};
`endif
      total_cnt++;
      if (obs !== want) $display("FAIL cont_single_cyc%0d got %b want %b", i, obs, want); else pass_cnt++;
      step;
    end
    stop = 1'b1;
    step; stop = 1'b0;
    want = {3'd4, 1'b0, 1'b0, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL cont_stop got %b want %b", obs, want); else pass_cnt++;
  endtask

  task automatic test_stop;
    chan_mask = 8'b0000_1010; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
    step; start = 1'b0;
    want = {3'd1, 1'b1, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL stop_first_ch got %b want %b", obs, want); else pass_cnt++;
    step; step; step; step;
`ifdef SCAN_BLANK_EN
    want = {3'd1, 1'b0, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL stop_blank got %b want %b", obs, want); else pass_cnt++;
    step;
`endif
    want = {3'd3, 1'b1, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL stop_second_ch got %b want %b", obs, want); else pass_cnt++;
    step;
    stop = 1'b1;
    step; stop = 1'b0;
    want = {3'd3, 1'b0, 1'b0, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL stop_idle got %b want %b", obs, want); else pass_cnt++;
    step;
    total_cnt++;
    if (obs !== want) $display("FAIL stop_no_pulse got %b want %b", obs, want); else pass_cnt++;
    start = 1'b1;
    step; start = 1'b0;
    want = {3'd1, 1'b1, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL restart_lowest got %b want %b", obs, want); else pass_cnt++;
    stop = 1'b1;
    step; stop = 1'b0;
    want = {3'd1, 1'b0, 1'b0, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL restart_stop got %b want %b", obs, want); else pass_cnt++;
  endtask

  task automatic test_ignored_starts;
    chan_mask = 8'h00; start = 1'b1;
    step; start = 1'b0;
    want = {3'd1, 1'b0, 1'b0, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL ign_zero_mask got %b want %b", obs, want); else pass_cnt++;
    chan_mask = 8'hFF; start = 1'b1; stop = 1'b1;
    step; start = 1'b0; stop = 1'b0;
    total_cnt++;
    if (obs !== want) $display("FAIL ign_start_stop got %b want %b", obs, want); else pass_cnt++;
    step;
    total_cnt++;
    if (obs !== want) $display("FAIL ign_start_stop_late got %b want %b", obs, want); else pass_cnt++;
    chan_mask = 8'b0100_0010; dwell = 8'd1; continuous = 1'b0; start = 1'b1;
    step;
    want = {3'd1, 1'b1, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL busy_start_ch1 got %b want %b", obs, want); else pass_cnt++;
    chan_mask = 8'h01;
    step;
    total_cnt++;
    if (obs !== want) $display("FAIL busy_start_hold got %b want %b", obs, want); else pass_cnt++;
    step;
`ifdef SCAN_BLANK_EN
    want = {3'd1, 1'b0, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL busy_start_blank got %b want %b", obs, want); else pass_cnt++;
    step;
`endif
    want = {3'd6, 1'b1, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL busy_start_ch6 got %b want %b", obs, want); else pass_cnt++;
    start = 1'b0; chan_mask = 8'h00;
    step; step;
`ifdef SCAN_BLANK_EN
    step;
`endif
    want = {3'd6, 1'b0, 1'b0, 1'b1}; total_cnt++;
    if (obs !== want) $display("FAIL busy_start_done got %b want %b", obs, want); else pass_cnt++;
  endtask

  task automatic test_relatch;
    chan_mask = 8'h03; dwell = 8'd1; continuous = 1'b1; start = 1'b1;
    step; start = 1'b0;
    chan_mask = 8'h80; dwell = 8'd0;
    want = {3'd0, 1'b1, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL relatch_ch0_a got %b want %b", obs, want); else pass_cnt++;
    step;
    total_cnt++;
    if (obs !== want) $display("FAIL relatch_ch0_b got %b want %b", obs, want); else pass_cnt++;
    step;
`ifdef SCAN_BLANK_EN
    want = {3'd0, 1'b0, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL relatch_blank0 got %b want %b", obs, want); else pass_cnt++;
    step;
`endif
    want = {3'd1, 1'b1, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL relatch_ch1_a got %b want %b", obs, want); else pass_cnt++;
    step;
    total_cnt++;
    if (obs !== want) $display("FAIL relatch_ch1_b got %b want %b", obs, want); else pass_cnt++;
    step;
`ifdef SCAN_BLANK_EN
    want = {3'd1, 1'b0, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL relatch_blank1 got %b want %b", obs, want); else pass_cnt++;
    step;
`endif
    want = {3'd7, 1'b1, 1'b1, 1'b1}; total_cnt++;
    if (obs !== want) $display("FAIL relatch_ch7_a got %b want %b", obs, want); else pass_cnt++;
    step;
`ifdef SCAN_BLANK_EN
    want = {3'd7, 1'b0, 1'b1, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL relatch_blank7 got %b want %b", obs, want); else pass_cnt++;
    step;
`endif
    want = {3'd7, 1'b1, 1'b1, 1'b1}; total_cnt++;
    if (obs !== want) $display("FAIL relatch_ch7_b got %b want %b", obs, want); else pass_cnt++;
    stop = 1'b1;
    step; stop = 1'b0;
    want = {3'd7, 1'b0, 1'b0, 1'b0}; total_cnt++;
    if (obs !== want) $display("FAIL relatch_stop got %b want %b", obs, want); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset;
    test_single_frame;
    test_continuous_single;
    test_stop;
    test_ignored_starts;
    test_relatch;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
